// File: rtl/fp_adder_sequencer_if.sv
// Bus/pin bundle between the parallel host, the sequencer and the serial FP adder.
// slave = sequencer side, master = host + adder side.
interface fp_adder_sequencer_if #(
  parameter int DATA_W  = 32,
  parameter int SETUP_W = 8
);
  logic              start_in;
  logic [DATA_W-1:0] op_a_in, op_b_in, op_c_in, op_d_in;
  logic [SETUP_W-1:0] setup_in;
  logic              input_rdy_in;
  logic              output_rdy_in;
  logic              serial_in;
  logic              serial1_out, serial2_out, serial3_out, serial4_out;
  logic              setup_serial_out;
  logic              wr_out;
  logic              output_read_out;
  logic              busy_out;
  logic              done_out;
  logic              error_out;
  logic [DATA_W-1:0] result_out;

  modport slave (
    input  start_in, op_a_in, op_b_in, op_c_in, op_d_in, setup_in,
           input_rdy_in, output_rdy_in, serial_in,
    output serial1_out, serial2_out, serial3_out, serial4_out, setup_serial_out,
           wr_out, output_read_out, busy_out, done_out, error_out, result_out
  );

  modport master (
    output start_in, op_a_in, op_b_in, op_c_in, op_d_in, setup_in,
           input_rdy_in, output_rdy_in, serial_in,
    input  serial1_out, serial2_out, serial3_out, serial4_out, setup_serial_out,
           wr_out, output_read_out, busy_out, done_out, error_out, result_out
  );
endinterface

// File: rtl/fp_adder_sequencer.sv
// Sequencer for the four-operand serial FP adder: parallel request -> serial load,
// wait, serial readback -> parallel result. FP_SEQ_TIMEOUT_EN bounds the wait.
module fp_adder_sequencer #(
  parameter int DATA_W  = 32,
  parameter int SETUP_W = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  fp_adder_sequencer_if.slave  bus
);
  localparam int CNT_W = 6;

  if (SETUP_W > DATA_W || TIMEOUT < 1) begin : g_param_chk
    $error("fp_adder_sequencer: bad parameters");
  end

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_READ, S_DONE} state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_sh_a, r_sh_b, r_sh_c, r_sh_d, r_sh_s;
  logic [DATA_W-2:0] r_shr;
  logic [DATA_W-1:0] r_result;
  logic              r_s1, r_s2, r_s3, r_s4, r_ss;
  logic              r_wr, r_rd, r_busy, r_done, r_err;
  logic [DATA_W-1:0] w_setup_ext;

  // Setup word rides in the low bits so it is shifted out last, after DATA_W-SETUP_W zeros.
  assign w_setup_ext = DATA_W'(bus.setup_in);

`ifdef FP_SEQ_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] r_tmo;
`endif

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_sh_a   <= '0;
      r_sh_b   <= '0;
      r_sh_c   <= '0;
      r_sh_d   <= '0;
      r_sh_s   <= '0;
      r_shr    <= '0;
      r_result <= '0;
      {r_s1, r_s2, r_s3, r_s4, r_ss} <= '0;
      {r_wr, r_rd, r_busy, r_done, r_err} <= '0;
`ifdef FP_SEQ_TIMEOUT_EN
      r_tmo    <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: if (bus.start_in && bus.input_rdy_in) begin
          // Present bit k=0 right away; the shift registers hold the rest.
          r_state <= S_LOAD;
          r_cnt   <= '0;
          r_busy  <= 1'b1;
          r_wr    <= 1'b1;
          r_s4    <= bus.op_a_in[DATA_W-1];
          r_s3    <= bus.op_b_in[DATA_W-1];
          r_s2    <= bus.op_c_in[DATA_W-1];
          r_s1    <= bus.op_d_in[DATA_W-1];
          r_ss    <= w_setup_ext[DATA_W-1];
          r_sh_a  <= bus.op_a_in << 1;
          r_sh_b  <= bus.op_b_in << 1;
          r_sh_c  <= bus.op_c_in << 1;
          r_sh_d  <= bus.op_d_in << 1;
          r_sh_s  <= w_setup_ext << 1;
        end
        S_LOAD: begin
          if (r_cnt == CNT_W'(DATA_W - 1)) begin
            r_state <= S_WAIT;
            r_wr    <= 1'b0;
            {r_s1, r_s2, r_s3, r_s4, r_ss} <= '0;
`ifdef FP_SEQ_TIMEOUT_EN
            r_tmo   <= '0;
`endif
          end else begin
            r_cnt  <= r_cnt + CNT_W'(1);
            r_s4   <= r_sh_a[DATA_W-1];
            r_s3   <= r_sh_b[DATA_W-1];
            r_s2   <= r_sh_c[DATA_W-1];
            r_s1   <= r_sh_d[DATA_W-1];
            r_ss   <= r_sh_s[DATA_W-1];
            r_sh_a <= r_sh_a << 1;
            r_sh_b <= r_sh_b << 1;
            r_sh_c <= r_sh_c << 1;
            r_sh_d <= r_sh_d << 1;
            r_sh_s <= r_sh_s << 1;
          end
        end
        S_WAIT: begin
          // A ready arriving on the last allowed cycle still beats the timeout.
          if (bus.output_rdy_in) begin
            r_state <= S_READ;
            r_cnt   <= '0;
            r_rd    <= 1'b1;
          end
`ifdef FP_SEQ_TIMEOUT_EN
          else if (r_tmo == TMO_W'(TIMEOUT - 1)) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_err   <= 1'b1;
          end else begin
            r_tmo   <= r_tmo + TMO_W'(1);
          end
`endif
        end
        S_READ: begin
          r_shr <= (DATA_W-1)'({r_shr, bus.serial_in});
          if (r_cnt == CNT_W'(DATA_W - 1)) begin
            r_state  <= S_DONE;
            r_rd     <= 1'b0;
            r_done   <= 1'b1;
            r_result <= {r_shr, bus.serial_in};
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.serial1_out      = r_s1;
  assign bus.serial2_out      = r_s2;
  assign bus.serial3_out      = r_s3;
  assign bus.serial4_out      = r_s4;
  assign bus.setup_serial_out = r_ss;
  assign bus.wr_out           = r_wr;
  assign bus.output_read_out  = r_rd;
  assign bus.busy_out         = r_busy;
  assign bus.done_out         = r_done;
  assign bus.error_out        = r_err;
  assign bus.result_out       = r_result;
endmodule

// File: tb/tb_fp_adder_sequencer.sv
// Scoreboard bench for fp_adder_sequencer with a behavioural serial-adder model.
module tb_fp_adder_sequencer;
  localparam int DW = 32;
  localparam int SW = 8;
`ifdef FP_SEQ_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 255;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fp_adder_sequencer_if #(.DATA_W(DW), .SETUP_W(SW)) bus();
  fp_adder_sequencer #(.DATA_W(DW), .SETUP_W(SW), .TIMEOUT(TMO)) dut (
    .clk_in(clk), .rst_in(rst), .bus(bus));

  typedef struct {
    logic [DW-1:0] a, b, c, d;
    logic [SW-1:0] s;
    logic [DW-1:0] r;
  } txn_t;

  txn_t          expq[$];
  logic [DW-1:0] resq[$];
  int unsigned   delq[$];

  int n_cmp = 0;
  int n_err = 0;

  // adder model state
  logic [DW-1:0] cap_a, cap_b, cap_c, cap_d, cap_s, cur_res;
  int  wcnt = 0, ridx = 0, wait_ctr = 0, since_fall = 0, wr_rises = 0;
  bit  prev_wr = 0, armed = 0, no_rdy = 0;
  logic [DW-1:0] exp_result = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Serial adder: collects the load streams, raises output_rdy after a delay,
  // then shifts the chosen result out MSB first while output_read_out is high.
  always @(negedge clk) begin : adder_model
    if (rst) begin
      prev_wr = 0; armed = 0; wcnt = 0; ridx = 0;
      bus.output_rdy_in = 1'b0;
      bus.serial_in = 1'b0;
    end else begin
      since_fall++;
      if (bus.wr_out && !prev_wr) begin
        wcnt = 0; wr_rises++;
        cap_a = '0; cap_b = '0; cap_c = '0; cap_d = '0; cap_s = '0;
      end
      if (bus.wr_out) begin
        cap_a = {cap_a[DW-2:0], bus.serial4_out};
        cap_b = {cap_b[DW-2:0], bus.serial3_out};
        cap_c = {cap_c[DW-2:0], bus.serial2_out};
        cap_d = {cap_d[DW-2:0], bus.serial1_out};
        cap_s = {cap_s[DW-2:0], bus.setup_serial_out};
        wcnt++;
      end
      if (!bus.wr_out && prev_wr) begin
        since_fall = 1;
        if (!no_rdy) begin
          armed    = 1;
          wait_ctr = (delq.size() > 0) ? int'(delq.pop_front()) : 2;
          cur_res  = (resq.size() > 0) ? resq.pop_front() : '0;
          ridx     = 0;
        end
      end
      prev_wr = bus.wr_out;
      if (armed) begin
        if (wait_ctr == 0) begin bus.output_rdy_in = 1'b1; armed = 0; end
        else wait_ctr--;
      end
      if (bus.output_read_out) begin
        bus.output_rdy_in = 1'b0;
        if (ridx < DW) bus.serial_in = cur_res[DW-1-ridx];
        ridx++;
      end
    end
  end

  always @(negedge clk) begin : monitor
    txn_t e;
    if (rst) exp_result = '0;
    else if (bus.done_out) begin
      if (expq.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL done_unexpected: got done_out=1 expected no pending op at %0t", $time);
      end else begin
        e = expq.pop_front();
        chk("wr_len",  64'(wcnt), 64'(DW));
        chk("op_a",    64'(cap_a), 64'(e.a));
        chk("op_b",    64'(cap_b), 64'(e.b));
        chk("op_c",    64'(cap_c), 64'(e.c));
        chk("op_d",    64'(cap_d), 64'(e.d));
        chk("setup",   64'(cap_s), 64'(DW'(e.s)));
        chk("result",  64'(bus.result_out), 64'(e.r));
        exp_result = e.r;
      end
    end else begin
      chk("result_hold", 64'(bus.result_out), 64'(exp_result));
`ifndef FP_SEQ_TIMEOUT_EN
      chk("error_low", 64'(bus.error_out), 64'(0));
`endif
    end
  end

  task automatic wait_idle();
    int t = 0;
    while (bus.busy_out && t < 2000) begin @(negedge clk); t++; end
    if (t >= 2000) begin
      n_cmp++; n_err++;
      $display("FAIL idle_timeout: got busy_out=1 expected 0 within 2000 cycles");
    end
  endtask

  task automatic issue(input logic [DW-1:0] a, b, c, d, input logic [SW-1:0] s,
                       input logic [DW-1:0] r, input int unsigned dly, input bit expect_done);
    wait_idle();
    if (expect_done) begin
      expq.push_back('{a: a, b: b, c: c, d: d, s: s, r: r});
      resq.push_back(r);
      delq.push_back(dly);
    end
    bus.op_a_in = a; bus.op_b_in = b; bus.op_c_in = c; bus.op_d_in = d;
    bus.setup_in = s;
    bus.start_in = 1'b1;
    @(negedge clk);
    bus.start_in = 1'b0;
    // operands must already be latched
    bus.op_a_in = $urandom; bus.op_b_in = $urandom;
    bus.op_c_in = $urandom; bus.op_d_in = $urandom;
    bus.setup_in = SW'($urandom);
  endtask

  initial begin
    int rises0, t;
    bus.start_in = 0; bus.input_rdy_in = 1; bus.setup_in = '0;
    bus.op_a_in = '0; bus.op_b_in = '0; bus.op_c_in = '0; bus.op_d_in = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'({bus.serial1_out, bus.serial2_out, bus.serial3_out, bus.serial4_out,
        bus.setup_serial_out, bus.wr_out, bus.output_read_out, bus.busy_out, bus.done_out,
        bus.error_out, bus.result_out}), 64'(0));
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_outputs", 64'({bus.serial1_out, bus.serial2_out, bus.serial3_out, bus.serial4_out,
          bus.setup_serial_out, bus.wr_out, bus.output_read_out, bus.busy_out, bus.done_out,
          bus.error_out, bus.result_out}), 64'(0));
    end

    // directed single op
    issue(32'h3F800000, 32'h40000000, 32'h0, 32'h0, 8'h1F, 32'h40400000, 2, 1);

    // back-to-back
    issue(32'hC0A00000, 32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F, 8'hE5, 32'hC0A00000, 0, 1);
    issue(32'h00000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000001, 8'h80, 32'h00000000, 1, 1);

    // start held high for a whole transaction
    wait_idle();
    rises0 = wr_rises;
    expq.push_back('{a: 32'hA5A5A5A5, b: 32'h5A5A5A5A, c: 32'h01234567, d: 32'h89ABCDEF,
                     s: 8'h3C, r: 32'hDEADBEEF});
    resq.push_back(32'hDEADBEEF); delq.push_back(4);
    bus.op_a_in = 32'hA5A5A5A5; bus.op_b_in = 32'h5A5A5A5A;
    bus.op_c_in = 32'h01234567; bus.op_d_in = 32'h89ABCDEF; bus.setup_in = 8'h3C;
    bus.start_in = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!bus.done_out && t < 500);
    bus.start_in = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);
    chk("held_start_one_op", 64'(wr_rises - rises0), 64'(1));

    // start while adder not ready
    rises0 = wr_rises;
    bus.input_rdy_in = 1'b0;
    bus.start_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("not_ready_ignored", 64'({bus.wr_out, bus.busy_out}), 64'(0));
    end
    bus.start_in = 1'b0;
    bus.input_rdy_in = 1'b1;
    chk("not_ready_no_load", 64'(wr_rises - rises0), 64'(0));

    // reset at LOAD cycle 10
    issue(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 8'h55, 32'h0, 0, 0);
    t = 0;
    while (wcnt < 10 && t < 100) begin @(negedge clk); t++; end
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("async_reset_drop", 64'({bus.wr_out, bus.busy_out}), 64'(0));
    expq.delete(); resq.delete(); delq.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rises0 = wr_rises;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("post_reset_quiet", 64'({bus.wr_out, bus.busy_out, bus.output_read_out}), 64'(0));
    end
    chk("post_reset_no_load", 64'(wr_rises - rises0), 64'(0));

    // randomized traffic
    for (int i = 0; i < 20; i++)
      issue($urandom, $urandom, $urandom, $urandom, SW'($urandom), $urandom,
            $urandom_range(0, 5), 1);

`ifdef FP_SEQ_TIMEOUT_EN
    // adder never answers
    wait_idle();
    no_rdy = 1;
    issue(32'h3F800000, 32'h3F800000, 32'h0, 32'h0, 8'h1F, 32'h0, 0, 0);
    t = 0;
    while (!bus.error_out && t < 500) begin @(negedge clk); t++; end
    chk("timeout_seen", 64'(bus.error_out), 64'(1));
    chk("timeout_latency", 64'(since_fall), 64'(TMO + 1));
    @(negedge clk);
    chk("timeout_pulse_end", 64'({bus.error_out, bus.busy_out}), 64'(0));
    no_rdy = 0;
    issue(32'h40000000, 32'h40000000, 32'h0, 32'h0, 8'h03, 32'h40800000, 1, 1);
`endif

    wait_idle();
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(expq.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
